// File: rtl/dmem_pkg.sv
// Shared definitions for the MEM-stage data-memory responder: FSM states and
// the bit layout of the serialized request word.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmemState_t;

    localparam int SERIAL_W = 65;
    localparam int WE_BIT   = 64;
    localparam int ADDR_MSB = 63;
    localparam int ADDR_LSB = 32;
    localparam int DATA_MSB = 31;
    localparam int DATA_LSB = 0;

endpackage

// File: rtl/dmem_array.sv
// Single-port 32-bit word array: synchronous write, asynchronous read.
// Defining DMEM_DUMP_EN prints the whole array once on the first terminateCPU strobe.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int ADDR_W      = 9
) (
    input  logic              CLK,
    input  logic              writeEn,
    input  logic [ADDR_W-1:0] index,
    input  logic [31:0]       writeData,
    output logic [31:0]       readData,
    input  logic              terminateCPU
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge CLK) begin
        if (writeEn) begin
            mem[index] <= writeData;
        end
    end

    assign readData = mem[index];

`ifdef DMEM_DUMP_EN
    // The dump ignores reset on purpose so an end-of-run strobe is never lost.
    bit dumpDone;

    always @(posedge CLK) begin
        if (terminateCPU && !dumpDone) begin
            dumpDone <= 1'b1;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                $display("%0h: %08h", i, mem[i]);
            end
        end
    end
`else
    logic unusedTerminate;
    assign unusedTerminate = terminateCPU;
`endif

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage data-memory interface: valid/ready request,
// fixed access latency, valid/ready response. Optional dump: DMEM_DUMP_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int ADDR_W      = 9,
    parameter int LATENCY     = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [SERIAL_W-1:0] EDIT_SERIAL,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [31:0]         DATA,
    output logic                resp_err,
    output logic                busy,
    input  logic                terminateCPU
);

    dmemState_t  state;
    dmemState_t  nextState;
    logic [3:0]  cnt;
    logic        reqWe;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;

    logic        accessNow;
    logic        accWe;
    logic [31:0] accAddr;
    logic [31:0] accWdata;
    logic        inRange;
    logic        arrayWriteEn;
    logic [31:0] arrayReadData;

    // With LATENCY=1 the access happens on the acceptance edge, so the live
    // request word is used instead of the latched copy.
    always_comb begin
        nextState  = state;
        accessNow  = 1'b0;
        accWe      = reqWe;
        accAddr    = reqAddr;
        accWdata   = reqWdata;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        nextState = RESP;
                        accessNow = 1'b1;
                        accWe     = EDIT_SERIAL[WE_BIT];
                        accAddr   = EDIT_SERIAL[ADDR_MSB:ADDR_LSB];
                        accWdata  = EDIT_SERIAL[DATA_MSB:DATA_LSB];
                    end else begin
                        nextState = WAIT;
                    end
                end
            end
            WAIT: begin
                busy = 1'b1;
                // cnt counts the WAIT edges still to come; the last one commits.
                if (cnt == 4'd1) begin
                    accessNow = 1'b1;
                    nextState = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                busy       = 1'b1;
                if (resp_ready) begin
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    assign inRange = (accAddr[31:ADDR_W] == '0) &&
                     ({{(32 - ADDR_W){1'b0}}, accAddr[ADDR_W-1:0]} < DEPTH_WORDS);

    // Gating with RESET drops a write whose commit edge coincides with reset.
    assign arrayWriteEn = accessNow && accWe && inRange && !RESET;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            DATA     <= 32'd0;
            resp_err <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE && req_valid) begin
                reqWe    <= EDIT_SERIAL[WE_BIT];
                reqAddr  <= EDIT_SERIAL[ADDR_MSB:ADDR_LSB];
                reqWdata <= EDIT_SERIAL[DATA_MSB:DATA_LSB];
                cnt      <= 4'(LATENCY - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end
            if (accessNow) begin
                if (!inRange) begin
                    DATA     <= 32'd0;
                    resp_err <= 1'b1;
                end else begin
                    DATA     <= accWe ? accWdata : arrayReadData;
                    resp_err <= 1'b0;
                end
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .ADDR_W     (ADDR_W)
    ) memArray (
        .CLK         (CLK),
        .writeEn     (arrayWriteEn),
        .index       (accAddr[ADDR_W-1:0]),
        .writeData   (accWdata),
        .readData    (arrayReadData),
        .terminateCPU(terminateCPU)
    );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one instance at LATENCY=2, one at
// LATENCY=1; a negedge monitor checks response timing and contents.
module tb_data_mem_responder;
    import dmem_pkg::*;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } expect_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic terminateCPU = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   acceptCyc = 0;

    logic                reqValid  [2];
    logic                reqReady  [2];
    logic [SERIAL_W-1:0] reqSerial [2];
    logic                respValid [2];
    logic                respReady [2];
    logic [31:0]         respData  [2];
    logic                respErr   [2];
    logic                busy      [2];
    logic                prevValid [2];

    expect_t scb0[$];
    expect_t scb1[$];

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    data_mem_responder #(.DEPTH_WORDS(512), .ADDR_W(9), .LATENCY(2)) dutLat2 (
        .CLK(CLK), .RESET(RESET),
        .req_valid(reqValid[0]), .req_ready(reqReady[0]), .EDIT_SERIAL(reqSerial[0]),
        .resp_valid(respValid[0]), .resp_ready(respReady[0]),
        .DATA(respData[0]), .resp_err(respErr[0]), .busy(busy[0]),
        .terminateCPU(terminateCPU)
    );

    data_mem_responder #(.DEPTH_WORDS(512), .ADDR_W(9), .LATENCY(1)) dutLat1 (
        .CLK(CLK), .RESET(RESET),
        .req_valid(reqValid[1]), .req_ready(reqReady[1]), .EDIT_SERIAL(reqSerial[1]),
        .resp_valid(respValid[1]), .resp_ready(respReady[1]),
        .DATA(respData[1]), .resp_err(respErr[1]), .busy(busy[1]),
        .terminateCPU(terminateCPU)
    );

    function automatic int latOf(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic int scbSize(input int k);
        return (k == 0) ? scb0.size() : scb1.size();
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: bound expired or unexpected event", name);
    endtask

    // Issue one request on instance k; optionally push its expected response.
    task automatic applyStimulus(input int k, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expData,
                                 input logic expErr, input logic expectResp);
        expect_t e;
        int guard = 0;
        while (!reqReady[k] && guard < 50) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (!reqReady[k]) begin
            failNow("req_ready_timeout");
            return;
        end
        reqValid[k]  = 1'b1;
        reqSerial[k] = {we, addr, wdata};
        @(posedge CLK); #1;
        acceptCyc    = cyc;
        reqValid[k]  = 1'b0;
        reqSerial[k] = {1'b1, 32'hFFFF_FFFF, 32'h5A5A_5A5A};
        if (expectResp) begin
            e.data = expData;
            e.err  = expErr;
            e.cyc  = acceptCyc + latOf(k) - 1;
            if (k == 0) scb0.push_back(e);
            else        scb1.push_back(e);
        end
    endtask

    task automatic waitDrain(input int k);
        int guard = 0;
        while (scbSize(k) != 0 && guard < 50) begin
            @(posedge CLK); #1;
            guard++;
        end
        if (scbSize(k) != 0) failNow("drain_timeout");
    endtask

    task automatic monitorStep(input int k);
        expect_t e;
        if (respValid[k] && !prevValid[k]) begin
            if (scbSize(k) == 0) begin
                failNow($sformatf("unexpected_resp%0d", k));
            end else begin
                e = (k == 0) ? scb0[0] : scb1[0];
                checkOutput($sformatf("latency%0d", k), cyc, e.cyc);
            end
        end
        if (respValid[k] && respReady[k] && scbSize(k) != 0) begin
            if (k == 0) e = scb0.pop_front();
            else        e = scb1.pop_front();
            checkOutput($sformatf("resp_data%0d", k), respData[k], e.data);
            checkOutput($sformatf("resp_err%0d", k), 32'(respErr[k]), 32'(e.err));
        end
        prevValid[k] = respValid[k];
    endtask

    initial begin
        prevValid[0] = 1'b0;
        prevValid[1] = 1'b0;
        forever begin
            @(negedge CLK);
            monitorStep(0);
            monitorStep(1);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int firstAccept;
        int guard;
        for (int k = 0; k < 2; k++) begin
            reqValid[k]  = 1'b0;
            reqSerial[k] = '0;
            respReady[k] = 1'b1;
        end
        RESET = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            checkOutput("reset_req_ready", 32'(reqReady[k]), 32'd1);
            checkOutput("reset_resp_valid", 32'(respValid[k]), 32'd0);
            checkOutput("reset_busy", 32'(busy[k]), 32'd0);
            checkOutput("reset_data", respData[k], 32'd0);
            checkOutput("reset_err", 32'(respErr[k]), 32'd0);
        end
        RESET = 1'b0;

        applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1);
        waitDrain(0);
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        waitDrain(0);

        // Backpressure: response must hold steady while resp_ready is low
        respReady[0] = 1'b0;
        applyStimulus(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1);
        guard = 0;
        while (!respValid[0] && guard < 20) begin
            @(posedge CLK); #1;
            guard++;
        end
        repeat (5) begin
            checkOutput("bp_valid", 32'(respValid[0]), 32'd1);
            checkOutput("bp_data", respData[0], 32'hDEADBEEF);
            checkOutput("bp_busy", 32'(busy[0]), 32'd1);
            checkOutput("bp_req_ready", 32'(reqReady[0]), 32'd0);
            @(posedge CLK); #1;
        end
        respReady[0] = 1'b1;
        @(posedge CLK); #1;
        checkOutput("bp_release_ready", 32'(reqReady[0]), 32'd1);
        checkOutput("bp_release_valid", 32'(respValid[0]), 32'd0);
        waitDrain(0);

        // Out-of-range accesses leave the array untouched
        applyStimulus(0, 1'b1, 32'h000, 32'h11111111, 32'h11111111, 1'b0, 1'b1);
        waitDrain(0);
        applyStimulus(0, 1'b1, 32'h1FF, 32'h22222222, 32'h22222222, 1'b0, 1'b1);
        waitDrain(0);
        applyStimulus(0, 1'b1, 32'h5, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b1);
        waitDrain(0);
        applyStimulus(0, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 1'b1);
        waitDrain(0);
        applyStimulus(0, 1'b1, 32'h200, 32'hBADBAD00, 32'h0, 1'b1, 1'b1);
        waitDrain(0);
        applyStimulus(0, 1'b1, 32'h8000_0005, 32'h0BAD0BAD, 32'h0, 1'b1, 1'b1);
        waitDrain(0);
        applyStimulus(0, 1'b0, 32'h000, 32'h0, 32'h11111111, 1'b0, 1'b1);
        waitDrain(0);
        applyStimulus(0, 1'b0, 32'h1FF, 32'h0, 32'h22222222, 1'b0, 1'b1);
        waitDrain(0);

        // Reset lands on the commit edge of a pending write
        applyStimulus(0, 1'b1, 32'h5, 32'h12345678, 32'h0, 1'b0, 1'b0);
        checkOutput("midreset_in_wait", 32'(busy[0]), 32'd1);
        RESET = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        checkOutput("midreset_req_ready", 32'(reqReady[0]), 32'd1);
        checkOutput("midreset_resp_valid", 32'(respValid[0]), 32'd0);
        checkOutput("midreset_busy", 32'(busy[0]), 32'd0);
        applyStimulus(0, 1'b0, 32'h5, 32'h0, 32'hCAFEF00D, 1'b0, 1'b1);
        waitDrain(0);

        // LATENCY=1 back-to-back with resp_ready tied high
        applyStimulus(1, 1'b1, 32'h7, 32'h0A0B0C0D, 32'h0A0B0C0D, 1'b0, 1'b1);
        firstAccept = acceptCyc;
        applyStimulus(1, 1'b0, 32'h7, 32'h0, 32'h0A0B0C0D, 1'b0, 1'b1);
        checkOutput("b2b_spacing", 32'(acceptCyc - firstAccept), 32'd2);
        applyStimulus(1, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 1'b1);
        waitDrain(1);

        repeat (3) @(posedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
